// File: rtl/mult_datapath_pkg.sv
// Parameter_Definitions: shared operand width and multiplier FSM state type.
package Parameter_Definitions;
  localparam int WORD_LENGTH = 16;
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/mult_datapath_bit_counter.sv
// bit_counter: iteration counter with a registered flag that stays set until clear.
module bit_counter #(
  parameter int WIDTH = 5,
  parameter int TERMINAL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             flag
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (enable) begin
      count <= count + 1'b1;
      if (count == WIDTH'(TERMINAL - 1)) flag <= 1'b1;
    end
  end
endmodule

// File: rtl/mult_datapath.sv
// mult_datapath: signed shift-and-add multiplier, one iteration per clock,
// operating on magnitudes and applying the sign on the final iteration.
module mult_datapath
  import Parameter_Definitions::*;
#(
  parameter int WORD_LENGTH = Parameter_Definitions::WORD_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     force_reset,
  input  logic [WORD_LENGTH-1:0]   multiplicand,
  input  logic [WORD_LENGTH-1:0]   multiplier,
  output logic                     counter_flag,
  output logic [2*WORD_LENGTH-1:0] product
);
  localparam int CW = $clog2(WORD_LENGTH) + 1;
  state_t state, state_next;
  logic [2*WORD_LENGTH-1:0] mcand, acc, acc_next;
  logic [WORD_LENGTH-1:0] mplier;
  logic [CW-1:0] count;
  logic sign, step, last;
  // Unsigned magnitude; the most negative value maps to 2^(W-1) without overflow.
  function automatic logic [WORD_LENGTH-1:0] mag(input logic [WORD_LENGTH-1:0] x);
    return x[WORD_LENGTH-1] ? -x : x;
  endfunction
  assign step     = !force_reset && state != DONE;
  assign last     = count == CW'(WORD_LENGTH - 1);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  bit_counter #(.WIDTH(CW), .TERMINAL(WORD_LENGTH)) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (force_reset),
    .enable (step),
    .count  (count),
    .flag   (counter_flag)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    if (force_reset) state_next = LOAD;
    else if (state != DONE) state_next = last ? DONE : RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      sign    <= 1'b0;
      acc     <= '0;
      product <= '0;
    end else if (force_reset) begin
      mcand   <= {{WORD_LENGTH{1'b0}}, mag(multiplicand)};
      mplier  <= mag(multiplier);
      sign    <= multiplicand[WORD_LENGTH-1] ^ multiplier[WORD_LENGTH-1];
      acc     <= '0;
      product <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) product <= sign ? -acc_next : acc_next;
    end
  end
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed corner cases plus random operands checked against signed integer multiply.
module tb_mult_datapath;
  logic clk = 0, rst = 1, force_reset = 0;
  logic [15:0] multiplicand = 0, multiplier = 0;
  logic counter_flag;
  logic [31:0] product;
  int n_cmp = 0, n_bad = 0;

  mult_datapath dut (
    .clk(clk), .rst(rst), .force_reset(force_reset),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .counter_flag(counter_flag), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 32'(p);
  endfunction

  task automatic load(input logic [15:0] a, input logic [15:0] b, input int cycles);
    @(negedge clk);
    force_reset = 1; multiplicand = a; multiplier = b;
    repeat (cycles) @(negedge clk);
    force_reset = 0;
  endtask

  task automatic wait_flag(output int edges);
    edges = 0;
    while (!counter_flag && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (!counter_flag) check("zero_while_busy", product, 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input int hold);
    int edges;
    logic [31:0] exp;
    exp = ref_mul(a, b);
    load(a, b, 2);
    wait_flag(edges);
    check({tag, "_latency"}, 32'(edges), 32'd16);
    check({tag, "_product"}, product, exp);
    if (hold > 0) begin
      multiplicand = 16'($urandom); multiplier = 16'($urandom);
      repeat (hold) @(posedge clk);
      #1;
      check({tag, "_hold_flag"}, 32'(counter_flag), 32'd1);
      check({tag, "_hold_product"}, product, exp);
    end
  endtask

  initial begin
    int edges;
    #2;
    check("reset_flag", 32'(counter_flag), 32'd0);
    check("reset_product", product, 32'd0);
    @(negedge clk); rst = 0;

    run_op("3x5", 16'd3, 16'd5, 10);
    check("3x5_const", product, 32'd15);
    run_op("m7x6", 16'hFFF9, 16'd6, 0);
    check("m7x6_const", product, 32'hFFFF_FFD6);
    run_op("min_x_min", 16'h8000, 16'h8000, 0);
    check("min_x_min_const", product, 32'h4000_0000);
    run_op("max_x_min", 16'h7FFF, 16'h8000, 0);
    check("max_x_min_const", product, 32'hC000_8000);
    run_op("0xm5", 16'd0, 16'hFFFB, 3);
    check("0xm5_const", product, 32'd0);
    run_op("m1xm1", 16'hFFFF, 16'hFFFF, 0);

    // abort mid-run with new operands loaded during the pulse
    load(16'd100, 16'd100, 1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    force_reset = 1; multiplicand = 16'd2; multiplier = 16'd9;
    @(posedge clk); #1;
    check("abort_flag", 32'(counter_flag), 32'd0);
    check("abort_product", product, 32'd0);
    @(negedge clk); force_reset = 0;
    wait_flag(edges);
    check("abort_latency", 32'(edges), 32'd16);
    check("abort_product_final", product, 32'd18);

    // operand changes during RUN are ignored
    load(16'd1234, 16'hFF00, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); multiplicand = 16'd7; multiplier = 16'd7;
    wait_flag(edges);
    check("ignore_latency", 32'(edges), 32'd13);
    check("ignore_product", product, ref_mul(16'd1234, 16'hFF00));

    // asynchronous reset between edges of a finished and then a running op
    run_op("pre_rst", 16'd50, 16'd60, 0);
    @(negedge clk); #2; rst = 1; #1;
    check("arst_done_flag", 32'(counter_flag), 32'd0);
    check("arst_done_product", product, 32'd0);
    @(negedge clk); rst = 0;
    load(16'd11, 16'd13, 1);
    repeat (5) @(posedge clk);
    #2; rst = 1; #1;
    check("arst_run_flag", 32'(counter_flag), 32'd0);
    check("arst_run_product", product, 32'd0);
    @(negedge clk); rst = 0;
    repeat (10) @(posedge clk);
    #1;
    check("arst_no_flag", 32'(counter_flag), 32'd0);
    run_op("post_rst", 16'd11, 16'd13, 0);

    for (int i = 0; i < 24; i++)
      run_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), (i % 4 == 0) ? 4 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 The block SHALL take parameter WORD_LENGTH, default 16, as the operand width in bits; it SHALL be defined in package Parameter_Definitions.
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 The block SHALL have port force_reset, input, 1 bit; high means hold in load/clear, low means run.
REQ-005 The block SHALL have port multiplicand, input, WORD_LENGTH bits, a two's-complement operand.
REQ-006 The block SHALL have port multiplier, input, WORD_LENGTH bits, a two's-complement operand.
REQ-007 The block SHALL have port counter_flag, output, 1 bit; high means the multiplication is complete.
REQ-008 The block SHALL have port product, output, 2*WORD_LENGTH bits, the registered two's-complement result.

Function
REQ-009 The block SHALL implement a three-state FSM: LOAD, RUN, DONE.
REQ-010 In every cycle with force_reset=1, from any state, the block SHALL do all of the following:
- enter LOAD;
- capture |multiplicand| into a 2*WORD_LENGTH shift register, zero-extended;
- capture |multiplier| into a WORD_LENGTH shift register;
- capture sign = MSB(multiplicand) XOR MSB(multiplier);
- clear the accumulator, the iteration counter, product and counter_flag.
REQ-011 Magnitude of the most negative input (-2^(WORD_LENGTH-1)) SHALL be taken as unsigned 2^(WORD_LENGTH-1), with no overflow.
REQ-012 On each rising edge with force_reset=0 in LOAD or RUN, the block SHALL perform one iteration:
- if the multiplier register LSB=1, add the multiplicand register to the accumulator;
- shift the multiplicand register left 1;
- shift the multiplier register right 1;
- increment the counter;
- be in state RUN.
REQ-013 The counter SHALL be $clog2(WORD_LENGTH)+1 bits wide and count iterations 1..WORD_LENGTH.
REQ-014 On the edge performing iteration WORD_LENGTH, the block SHALL load product with the accumulator result, two's-complement negated when sign=1, set counter_flag=1, and enter DONE.
REQ-015 The first force_reset=0 edge after load SHALL be iteration 1, so counter_flag rises exactly WORD_LENGTH edges after force_reset falls.
REQ-016 In DONE with force_reset=0, all registers SHALL hold, and counter_flag and product SHALL stay stable indefinitely.
REQ-017 Operand input changes while not in LOAD SHALL have no effect.
REQ-018 force_reset asserted mid-RUN SHALL abort at the next edge per REQ-010, with no partial product visible.
REQ-019 product SHALL read 0 whenever counter_flag=0.
REQ-020 A product of zero SHALL never be negated to a nonzero value, including for a zero operand with sign=1.

Reset
REQ-021 rst=1 SHALL asynchronously force LOAD, counter_flag=0, product=0, accumulator=0, counter=0 and both shift registers to 0.
REQ-022 After rst falls, the block SHALL behave per REQ-010/REQ-012 on the next edge; rst mid-RUN SHALL discard the operation.

Structure
REQ-023 WORD_LENGTH and the FSM state enum type SHALL live in package Parameter_Definitions.
REQ-024 The iteration counter SHALL be a sub-module bit_counter, with:
- parameters: width and terminal count;
- ports: clk, rst, clear, enable, flag;
- flag registered and sticky until clear.
REQ-025 The block SHALL connect directly to the existing control unit's Force_reset output and counter_Flag input, with no glue logic.

Verification (WORD_LENGTH=16)
REQ-026 Scenario: 3 x 5, force_reset high for 2 cycles then low -> counter_flag high exactly 16 edges later, product=32'd15, and both hold for 10 further cycles.
REQ-027 Scenario: -7 x 6 -> product=32'hFFFF_FFD6 (-42).
REQ-028 Scenario: -32768 x -32768 -> product=32'h4000_0000; also 32767 x -32768 -> product=32'hC000_8000.
REQ-029 Scenario: 0 x -5 -> product=0, counter_flag after 16 edges.
REQ-030 Scenario: 100 x 100 with force_reset pulsed at iteration 8, operands changed to 2 x 9 during the pulse -> counter_flag 16 edges after force_reset falls, product=18.
REQ-031 Scenario: rst pulsed asynchronously mid-RUN (between edges) -> outputs 0 immediately, no counter_flag until a new force_reset/run sequence completes.
